// File: rtl/serial_parity_receiver.sv
// Receiver for the XOR-parity serial link: start bit, DATA_BITS data bits LSB-first,
// parity bit, stop bit. Emits each word with a one-cycle valid pulse and error flags.
module serial_parity_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int             CW       = $clog2(DATA_BITS + 1);
  localparam logic           ODD_BIT  = (ODD_PARITY != 0);
  localparam logic [CW-1:0]  LAST_CNT = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] data_q;
  logic [CW-1:0]        cnt_q;
  logic                 acc_q;
  logic                 perr_q;
  logic                 valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 busy_q;

  // New bits enter at the MSB so the first bit received settles at bit 0.
  always_comb begin
    shift_d                = shift_q >> 1;
    shift_d[DATA_BITS-1]   = rx_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      perr_q       <= 1'b0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!rx_in) begin
              cnt_q   <= '0;
              acc_q   <= 1'b0;
              state_q <= DATA;
              busy_q  <= 1'b1;
            end
          end
          DATA: begin
            shift_q <= shift_d;
            acc_q   <= acc_q ^ rx_in;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            perr_q  <= acc_q ^ rx_in ^ ODD_BIT;
            state_q <= STOP;
          end
          STOP: begin
            data_q       <= shift_q;
            parity_err_q <= perr_q;
            frame_err_q  <= ~rx_in;
            valid_q      <= 1'b1;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: doc/serial_parity_receiver.md
Name: serial_parity_receiver

Overview:
Receiving end of the team's XOR-based even/odd parity link. It deserialises a framed bit stream (start, DATA_BITS data LSB-first, parity, stop), accumulates the running XOR of the data bits, and checks it against the received parity bit. It sits between a bit-strobe source and byte-wide consumer logic, and delivers each word with a one-cycle valid pulse plus error flags.

Parameters:
DATA_BITS, 8, number of data bits per frame (legal range 1..16).
ODD_PARITY, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (that XOR must be 1).

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
bit_en  input  1  bit strobe; rx_in is sampled only on cycles where bit_en=1.
rx_in  input  1  serial line; idles high (1).
data_out  output  DATA_BITS  last received word; held until the next frame completes.
data_valid  output  1  one-cycle pulse when a frame completes, good or bad.
parity_err  output  1  valid together with data_valid: 1 = parity mismatch.
frame_err  output  1  valid together with data_valid: 1 = stop bit sampled as 0.
busy  output  1  1 while in any state other than IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE; data_out=0; data_valid=0; parity_err=0; frame_err=0; busy=0; shift register, bit counter and parity accumulator cleared. Reset asserted mid-frame aborts the frame and emits no data_valid.
- Cycles with bit_en=0 change no state. data_valid still drops after its single cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on bit_en=1 with rx_in=0 (start bit): clear count and accumulator, go to DATA. On bit_en=1 with rx_in=1: stay in IDLE.
  - DATA: on each bit_en, shift rx_in into shift register at the MSB end, moving toward the LSB, so the first bit received ends up at bit 0. acc <= acc ^ rx_in; count++. After the DATA_BITS-th bit, go to PARITY.
  - PARITY: on bit_en, latch perr = acc ^ rx_in ^ ODD_PARITY (1 = error). Go to STOP.
  - STOP: on bit_en, in one registered update: data_out <= shift register; parity_err <= perr; frame_err <= ~rx_in; data_valid <= 1 for exactly one clk. Go to IDLE.
- Latency: data_valid is asserted in the cycle after the clk edge that sampled the stop bit.
- Back-to-back frames: a start bit on the bit_en immediately after the stop bit is accepted. There is no idle-bit requirement.
- parity_err and frame_err hold their values until the next data_valid. Both may be 1 together.
- The bit counter width is ceil(log2(DATA_BITS+1)). The counter never wraps within a frame.
- A glitch where rx_in=0 without bit_en is ignored; only strobed samples count.

Test Plan:
1. Even parity, DATA_BITS=8. Reset, then frame 0,[1,0,1,0,0,0,0,0],parity 0,stop 1 with bit_en every cycle -> data_out=8'h05, data_valid pulse of 1 cycle, parity_err=0, frame_err=0, busy=0 afterwards.
2. Same frame but parity bit=1 -> data_out=8'h05, parity_err=1, frame_err=0.
3. Frame for 8'hFF, parity 0, stop bit 0 -> data_out=8'hFF, parity_err=0, frame_err=1.
4. ODD_PARITY=1, frame for 8'h00 with parity 1, immediately followed by a frame for 8'h01 with parity 0 -> two data_valid pulses, 8'h00 then 8'h01, parity_err=0 both times.
5. bit_en asserted every 4th cycle while rx_in toggles between strobes; frame for 8'hA5 -> data_out=8'hA5 with no errors; only strobed samples are used.
6. Reset asserted after 3 data bits, then released, then a full frame for 8'h3C -> no data_valid during the aborted frame; after release all outputs are 0; data_out=8'h3C on the next frame.
